fp_scaleb_fixup128: RTL and testbench

// Consumes the unclamped exponent sum and significand from the FP128 scaleb stage.

---
 rtl/fp_scaleb_fixup128.sv | 163 ++++++++++++++++
 tb/tb_fp_scaleb_fixup128.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/fp_scaleb_fixup128.sv
// FP128 scaleb fix-up: renormalises subnormal sources, denormalises tiny results with
// round-to-nearest-even, saturates overflow to infinity and raises IEEE flags.
module fp_scaleb_fixup128 #(
    parameter int SHIFT_STEP = 16,
    parameter int BIAS       = 16383
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_v,
    output logic               i_rdy,
    input  logic               i_sign,
    input  logic signed [16:0] i_xs,
    input  logic               i_hid,
    input  logic [111:0]       i_sig,
    input  logic               i_nan,
    input  logic               i_inf,
    output logic               o_v,
    input  logic               o_rdy,
    output logic [127:0]       o,
    output logic               o_of,
    output logic               o_uf,
    output logic               o_inx
);
    localparam logic signed [16:0] EXP_OVF = 17'(2 * BIAS + 1);
    localparam logic signed [16:0] EXP_ONE = 17'sd1;
    localparam logic [6:0]         REM_MAX = 7'd116;
    localparam logic [6:0]         STEP    = 7'(SHIFT_STEP);

    typedef enum logic [2:0] {IDLE, NORM, DENORM, ROUND, DONE} state_t;
    state_t state, state_n;

    logic [112:0]       m;
    logic               g, s, sign, nan, inf, ovf, tiny;
    logic signed [16:0] e;
    logic [6:0]         rem;

    logic               acc, acc_spec, acc_ovf, acc_norm, acc_den;
    logic signed [17:0] den_amt;
    logic [6:0]         rem_init;
    logic [112:0]       m_nrm;
    logic signed [16:0] e_nrm;
    logic               nrm_last;
    logic [6:0]         k;
    logic [113:0]       mg_sh;
    logic               lost;
    logic [127:0]       res;
    logic               res_of, res_uf, res_inx;

    function automatic logic [127:0] rne_pack(input logic sgn, input logic [112:0] mant,
                                              input logic grd, input logic stk,
                                              input logic [14:0] ex);
        logic [112:0] mr;
        mr = mant + {112'd0, grd & (stk | mant[0])};
        // A round-up carry into the hidden position lands on exponent 1 (e is 1 after denorm).
        return {sgn, mr[112] ? ex : 15'd0, mr[111:0]};
    endfunction

    function automatic logic [127:0] sat_inf(input logic sgn);
        return {sgn, 15'h7fff, 112'd0};
    endfunction

    assign i_rdy = (state == IDLE);

    always_comb begin
        acc      = i_v && (state == IDLE);
        acc_spec = i_nan || i_inf || ({i_hid, i_sig} == 113'd0);
        acc_ovf  = !acc_spec && (i_xs >= EXP_OVF);
        acc_norm = !acc_spec && !acc_ovf && !i_hid && (i_xs > EXP_ONE);
        acc_den  = !acc_spec && !acc_ovf && !acc_norm && (i_xs < EXP_ONE);
        den_amt  = 18'sd1 - $signed({i_xs[16], i_xs});
        rem_init = (den_amt > 18'sd116) ? REM_MAX : den_amt[6:0];

        m_nrm    = m << 1;
        e_nrm    = e - EXP_ONE;
        nrm_last = m_nrm[112] || (e_nrm <= EXP_ONE);

        // Shifts of 114 or more clear the vector and push every bit into sticky.
        k     = (rem < STEP) ? rem : STEP;
        mg_sh = {m, g} >> k;
        lost  = |({m, g} & ~({114{1'b1}} << k));

        res     = rne_pack(sign, m, g, s, e[14:0]);
        res_of  = 1'b0;
        res_inx = g | s;
        res_uf  = tiny & (g | s);
        if (nan) begin
            res     = {sign, 15'h7fff, m[111:0]};
            res_inx = 1'b0;
            res_uf  = 1'b0;
        end else if (inf) begin
            res     = sat_inf(sign);
            res_inx = 1'b0;
            res_uf  = 1'b0;
        end else if (ovf) begin
            res     = sat_inf(sign);
            res_of  = 1'b1;
            res_inx = 1'b1;
            res_uf  = 1'b0;
        end

        state_n = state;
        unique case (state)
            IDLE: begin
                if (acc) begin
                    if (acc_norm)     state_n = NORM;
                    else if (acc_den) state_n = DENORM;
                    else              state_n = ROUND;
                end
            end
            NORM:    if (nrm_last) state_n = ROUND;
            DENORM:  if (rem == k) state_n = ROUND;
            ROUND:   state_n = DONE;
            DONE:    if (o_rdy) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (acc) begin
            m    <= {i_hid, i_sig};
            g    <= 1'b0;
            s    <= 1'b0;
            sign <= i_sign;
            nan  <= i_nan;
            inf  <= i_inf & ~i_nan;
            ovf  <= acc_ovf;
            tiny <= acc_den;
            e    <= acc_den ? EXP_ONE : i_xs;
            rem  <= rem_init;
        end else if (state == NORM) begin
            if (!m[112] && (e > EXP_ONE)) begin
                m <= m_nrm;
                e <= e_nrm;
            end
        end else if (state == DENORM) begin
            {m, g} <= mg_sh;
            s      <= s | lost;
            rem    <= rem - k;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            o_v   <= 1'b0;
            o     <= 128'd0;
            o_of  <= 1'b0;
            o_uf  <= 1'b0;
            o_inx <= 1'b0;
        end else begin
            state <= state_n;
            if (state == ROUND) begin
                o_v   <= 1'b1;
                o     <= res;
                o_of  <= res_of;
                o_uf  <= res_uf;
                o_inx <= res_inx;
            end else if ((state == DONE) && o_rdy) begin
                o_v <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fp_scaleb_fixup128.sv
// Directed bench for fp_scaleb_fixup128 with a value-level reference model and a
// per-cycle output monitor.
module tb_fp_scaleb_fixup128;
    localparam int STEP = 16;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               i_v = 1'b0;
    logic               i_rdy;
    logic               i_sign = 1'b0;
    logic signed [16:0] i_xs = 17'sd0;
    logic               i_hid = 1'b0;
    logic [111:0]       i_sig = 112'd0;
    logic               i_nan = 1'b0;
    logic               i_inf = 1'b0;
    logic               o_v;
    logic               o_rdy = 1'b0;
    logic [127:0]       o;
    logic               o_of, o_uf, o_inx;

    int checks = 0;
    int errors = 0;
    logic [127:0] exp_o = 128'd0;
    logic [2:0]   exp_f = 3'd0;
    bit           armed = 1'b0;

    typedef struct {
        logic [127:0] o;
        logic         of;
        logic         uf;
        logic         inx;
        int           lat;
    } res_t;

    fp_scaleb_fixup128 #(.SHIFT_STEP(STEP), .BIAS(16383)) dut (
        .clk(clk), .rst_n(rst_n), .i_v(i_v), .i_rdy(i_rdy), .i_sign(i_sign),
        .i_xs(i_xs), .i_hid(i_hid), .i_sig(i_sig), .i_nan(i_nan), .i_inf(i_inf),
        .o_v(o_v), .o_rdy(o_rdy), .o(o), .o_of(o_of), .o_uf(o_uf), .o_inx(o_inx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Value-level reference: one exact wide shift instead of chunked steps.
    function automatic res_t model(input logic sn, input int xs, input logic hid,
                                   input logic [111:0] sig, input logic nan, input logic inf);
        res_t r;
        logic [112:0] m;
        logic [240:0] x;
        logic [112:0] q;
        logic gd, st;
        int n, sh, e;
        m = {hid, sig};
        r.of = 1'b0; r.uf = 1'b0; r.inx = 1'b0; r.lat = 2;
        if (nan) r.o = {sn, 15'h7fff, sig};
        else if (inf) r.o = {sn, 15'h7fff, 112'd0};
        else if (m == 113'd0) r.o = {sn, 127'd0};
        else if (xs >= 32767) begin
            r.o = {sn, 15'h7fff, 112'd0};
            r.of = 1'b1; r.inx = 1'b1;
        end else if (!hid && xs > 1) begin
            n = 0;
            while (m[112 - n] == 1'b0) n++;
            sh = (n < xs - 1) ? n : xs - 1;
            m = m << sh;
            e = xs - sh;
            r.lat = 2 + sh;
            r.o = {sn, m[112] ? e[14:0] : 15'd0, m[111:0]};
        end else if (xs < 1) begin
            sh = (1 - xs > 116) ? 116 : 1 - xs;
            x = {m, 128'd0} >> sh;
            q = x[240:128];
            gd = x[127];
            st = |x[126:0];
            if (gd && (st || q[0])) q = q + 113'd1;
            r.o = {sn, q[112] ? 15'd1 : 15'd0, q[111:0]};
            r.inx = gd | st;
            r.uf = gd | st;
            r.lat = 2 + (sh + STEP - 1) / STEP;
        end else begin
            r.o = {sn, hid ? xs[14:0] : 15'd0, sig};
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if (rst_n && o_v) begin
            if (!armed) chk("spurious_ov", 128'(o_v), 128'd0);
            else begin
                chk("o", o, exp_o);
                chk("flags", 128'({o_of, o_uf, o_inx}), 128'(exp_f));
                chk("i_rdy_busy", 128'(i_rdy), 128'd0);
            end
        end
    end

    task automatic drive(input logic sn, input int xs, input logic hid, input logic [111:0] sig,
                         input logic nan, input logic inf);
        i_v = 1'b1; i_sign = sn; i_xs = xs[16:0]; i_hid = hid; i_sig = sig;
        i_nan = nan; i_inf = inf;
        @(posedge clk); #1;
        i_v = 1'b0; i_nan = 1'b0; i_inf = 1'b0;
    endtask

    task automatic send(input logic sn, input int xs, input logic hid, input logic [111:0] sig,
                        input logic nan, input logic inf, input int stall, input bit lit,
                        input logic [127:0] lo, input logic [2:0] lf, input int ll);
        res_t r;
        int lat;
        r = model(sn, xs, hid, sig, nan, inf);
        if (lit) begin
            chk("model_o", r.o, lo);
            chk("model_flags", 128'({r.of, r.uf, r.inx}), 128'(lf));
            chk("model_lat", 128'(r.lat), 128'(ll));
        end
        @(posedge clk); #1;
        chk("i_rdy_idle", 128'(i_rdy), 128'd1);
        exp_o = r.o;
        exp_f = {r.of, r.uf, r.inx};
        armed = 1'b1;
        drive(sn, xs, hid, sig, nan, inf);
        lat = 1;
        while (!o_v && lat < 400) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", 128'(lat), 128'(r.lat));
        if (!o_v) begin
            armed = 1'b0;
            rst_n = 1'b0; #1; rst_n = 1'b1;
        end else begin
            repeat (stall) begin
                @(posedge clk); #1;
                chk("stall_ov", 128'(o_v), 128'd1);
            end
            o_rdy = 1'b1;
            @(posedge clk); #1;
            o_rdy = 1'b0;
            armed = 1'b0;
            chk("ov_drop", 128'(o_v), 128'd0);
            chk("rdy_back", 128'(i_rdy), 128'd1);
        end
    endtask

    initial begin
        int lat;
        #1;
        chk("rst_ov", 128'(o_v), 128'd0);
        chk("rst_o", o, 128'd0);
        chk("rst_flags", 128'({o_of, o_uf, o_inx}), 128'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_rdy", 128'(i_rdy), 128'd1);

        send(1'b0, 16384, 1'b1, 112'd0, 1'b0, 1'b0, 0, 1'b1,
             128'h4000_0000_0000_0000_0000_0000_0000_0000, 3'b000, 2);
        send(1'b0, 0, 1'b1, 112'd0, 1'b0, 1'b0, 0, 1'b1,
             128'h0000_8000_0000_0000_0000_0000_0000_0000, 3'b000, 3);
        send(1'b0, 0, 1'b1, {112{1'b1}}, 1'b0, 1'b0, 0, 1'b1,
             128'h0001_0000_0000_0000_0000_0000_0000_0000, 3'b011, 3);
        send(1'b1, 32767, 1'b1, 112'h1234, 1'b0, 1'b0, 0, 1'b1,
             128'hFFFF_0000_0000_0000_0000_0000_0000_0000, 3'b101, 2);
        send(1'b0, 40000, 1'b1, 112'h8000_0000_0000_0000_0000_0000_0001, 1'b1, 1'b0, 0, 1'b1,
             128'h7FFF_8000_0000_0000_0000_0000_0000_0001, 3'b000, 2);
        send(1'b0, -200, 1'b1, 112'h5555, 1'b0, 1'b0, 0, 1'b1,
             128'h0000_0000_0000_0000_0000_0000_0000_0000, 3'b011, 10);
        send(1'b0, 5, 1'b0, 112'h8000_0000_0000_0000_0000_0000_0000, 1'b0, 1'b0, 5, 1'b1,
             128'h0004_0000_0000_0000_0000_0000_0000_0000, 3'b000, 3);
        send(1'b1, 100, 1'b1, 112'hABC, 1'b0, 1'b1, 0, 1'b1,
             128'hFFFF_0000_0000_0000_0000_0000_0000_0000, 3'b000, 2);
        send(1'b1, -50, 1'b0, 112'd0, 1'b0, 1'b0, 0, 1'b1,
             128'h8000_0000_0000_0000_0000_0000_0000_0000, 3'b000, 2);
        send(1'b0, 0, 1'b1, 112'd1, 1'b0, 1'b0, 0, 1'b1,
             128'h0000_8000_0000_0000_0000_0000_0000_0000, 3'b011, 3);
        send(1'b0, 0, 1'b1, 112'd3, 1'b0, 1'b0, 0, 1'b1,
             128'h0000_8000_0000_0000_0000_0000_0000_0002, 3'b011, 3);

        send(1'b0, 5, 1'b0, 112'h4000_0000_0000_0000_0000_0000_0000, 1'b0, 1'b0, 0, 1'b0, 128'd0, 3'd0, 0);
        send(1'b1, -20, 1'b1, 112'h1234_5678_9ABC_DEF0_0FED_CBA9_8765, 1'b0, 1'b0, 2, 1'b0, 128'd0, 3'd0, 0);
        send(1'b0, 3, 1'b0, 112'd1 << 90, 1'b0, 1'b0, 0, 1'b0, 128'd0, 3'd0, 0);
        send(1'b0, 1, 1'b0, 112'h1234, 1'b0, 1'b0, 0, 1'b0, 128'd0, 3'd0, 0);
        send(1'b0, 32766, 1'b1, 112'hFFFF_0000_1111, 1'b0, 1'b0, 0, 1'b0, 128'd0, 3'd0, 0);
        send(1'b1, -65536, 1'b1, {112{1'b1}}, 1'b0, 1'b0, 0, 1'b0, 128'd0, 3'd0, 0);
        send(1'b0, -111, 1'b1, 112'hF0F0_F0F0, 1'b0, 1'b0, 0, 1'b0, 128'd0, 3'd0, 0);
        send(1'b0, 20000, 1'b0, 112'd7, 1'b0, 1'b0, 0, 1'b0, 128'd0, 3'd0, 0);

        // Reset in the middle of a long denormalisation.
        @(posedge clk); #1;
        drive(1'b0, -200, 1'b1, 112'd0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #2; rst_n = 1'b0; #1;
        chk("rst_mid_ov", 128'(o_v), 128'd0);
        chk("rst_mid_rdy", 128'(i_rdy), 128'd1);
        chk("rst_mid_o", o, 128'd0);
        @(negedge clk); rst_n = 1'b1;

        // Reset while a result is being held.
        @(posedge clk); #1;
        drive(1'b0, 16384, 1'b1, 112'd0, 1'b0, 1'b0);
        lat = 1;
        while (!o_v && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("done_ov_seen", 128'(o_v), 128'd1);
        #1; rst_n = 1'b0; #1;
        chk("rst_done_ov", 128'(o_v), 128'd0);
        chk("rst_done_o", o, 128'd0);
        @(negedge clk); rst_n = 1'b1;

        send(1'b1, 16383, 1'b1, 112'd0, 1'b0, 1'b0, 0, 1'b1,
             128'hBFFF_0000_0000_0000_0000_0000_0000_0000, 3'b000, 2);

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
